// File: rtl/dram_pkg.sv
// Shared definitions for the DRAM request queue: FSM state encoding,
// command encoding and the FIFO entry layout {we, addr, wdata}.
package dram_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_RUN   = 2'd2,
        S_RDATA = 2'd3
    } state_e;

    localparam logic CMD_WRITE = 1'b1;
    localparam logic CMD_READ  = 1'b0;

    // Width of one queued request: write flag, address, write data.
    function automatic int entry_width(input int aw, input int dw);
        return 1 + aw + dw;
    endfunction

endpackage

// File: rtl/dram_req_fifo.sv
// DEPTH-entry synchronous FIFO with extra-MSB pointers for full/empty.
// The head entry is presented combinationally on data_o.
module dram_req_fifo #(
    parameter int WIDTH = 15,
    parameter int DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int PW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_q, wr_d;
    logic [PW-1:0]    rd_q, rd_d;

    assign wr_d = wr_q + {{(PW-1){1'b0}}, push_i};
    assign rd_d = rd_q + {{(PW-1){1'b0}}, pop_i};

    // Storage is not reset; only the pointers define validity.
    always_ff @(posedge clk_i) begin
        if (push_i) mem_q[wr_q[PW-2:0]] <= data_i;
    end

    // Pointer registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    assign data_o  = mem_q[rd_q[PW-2:0]];
    assign empty_o = (wr_q == rd_q);
    assign full_o  = (wr_q[PW-1] != rd_q[PW-1]) && (wr_q[PW-2:0] == rd_q[PW-2:0]);

endmodule

// File: rtl/dram_req_queue.sv
// Host-side request queue in front of the DRAM controller. Issues one request
// at a time, confirms execution by snooping RAS_n/CAS_n, replays requests
// displaced by refresh and returns read data in order.
// Optional DRAM_REQ_QUEUE_STATS_EN adds saturating read/write/replay counters.
module dram_req_queue
    import dram_pkg::*;
#(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 2,
    parameter int DEPTH      = 4
) (
    input  logic                  u_clk,
    input  logic                  u_rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  ctl_en,
    output logic [ADDR_WIDTH-1:0] ctl_addr,
    output logic                  ctl_cmd,
    output logic [DATA_WIDTH-1:0] ctl_wdata,
    input  logic                  ctl_cmd_ack,
    input  logic                  ctl_busy,
    input  logic [DATA_WIDTH-1:0] ctl_rdata,
    input  logic                  ctl_rdata_vld,
    input  logic                  mon_ras_n,
    input  logic                  mon_cas_n
`ifdef DRAM_REQ_QUEUE_STATS_EN
    ,
    output logic [15:0]           stat_rd,
    output logic [15:0]           stat_wr,
    output logic [15:0]           stat_replay
`endif
);
    localparam int EW = entry_width(ADDR_WIDTH, DATA_WIDTH);

    state_e                state_q, state_d;
    logic                  col_seen_q, col_seen_d;
    logic                  rsp_valid_q;
    logic [DATA_WIDTH-1:0] rsp_data_q;
    logic                  full, empty, push, retire, replay, rsp_load;
    logic                  head_we, col_now, col_hit;
    logic [EW-1:0]         head;

    assign push      = req_valid & ~full;
    assign req_ready = ~full;

    dram_req_fifo #(.WIDTH(EW), .DEPTH(DEPTH)) u_fifo (
        .clk_i   (u_clk),
        .rst_n_i (u_rst_n),
        .push_i  (push),
        .data_i  ({req_we, req_addr, req_wdata}),
        .pop_i   (retire),
        .data_o  (head),
        .full_o  (full),
        .empty_o (empty)
    );

    assign {head_we, ctl_addr, ctl_wdata} = head;
    assign ctl_cmd = head_we;

    // A column command is RAS_n high with CAS_n low; refresh drives both low.
    assign col_now = mon_ras_n & ~mon_cas_n;
    assign col_hit = col_seen_q | col_now;

    // Issue FSM: next state, controller enable and retire/replay decisions.
    always_comb begin
        state_d    = state_q;
        col_seen_d = col_seen_q;
        ctl_en     = 1'b0;
        retire     = 1'b0;
        replay     = 1'b0;
        rsp_load   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!empty) state_d = S_ISSUE;
            end
            S_ISSUE: begin
                ctl_en     = 1'b1;
                col_seen_d = 1'b0;
                if (ctl_cmd_ack) state_d = S_RUN;
            end
            S_RUN: begin
                // Dropping enable with busy keeps the controller parked in idle.
                ctl_en = ctl_busy;
                if (col_now) col_seen_d = 1'b1;
                if (!ctl_busy) begin
                    if (!col_hit) begin
                        replay  = 1'b1;
                        state_d = S_ISSUE;
                    end else begin
                        case (head_we)
                            CMD_WRITE: begin
                                retire  = 1'b1;
                                state_d = S_IDLE;
                            end
                            CMD_READ: state_d = S_RDATA;
                        endcase
                    end
                end
            end
            S_RDATA: begin
                if (ctl_rdata_vld) begin
                    rsp_load = 1'b1;
                    retire   = 1'b1;
                    state_d  = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State, column-seen flag and response register.
    always_ff @(posedge u_clk or negedge u_rst_n) begin
        if (!u_rst_n) begin
            state_q     <= S_IDLE;
            col_seen_q  <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            col_seen_q  <= col_seen_d;
            rsp_valid_q <= rsp_load;
            if (rsp_load) rsp_data_q <= ctl_rdata;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;

`ifdef DRAM_REQ_QUEUE_STATS_EN
    logic [15:0] stat_rd_q, stat_wr_q, stat_replay_q;

    // Saturating retire/replay counters.
    always_ff @(posedge u_clk or negedge u_rst_n) begin
        if (!u_rst_n) begin
            stat_rd_q     <= '0;
            stat_wr_q     <= '0;
            stat_replay_q <= '0;
        end else begin
            if (retire && head_we == CMD_READ && stat_rd_q != 16'hFFFF)
                stat_rd_q <= stat_rd_q + 16'd1;
            if (retire && head_we == CMD_WRITE && stat_wr_q != 16'hFFFF)
                stat_wr_q <= stat_wr_q + 16'd1;
            if (replay && stat_replay_q != 16'hFFFF)
                stat_replay_q <= stat_replay_q + 16'd1;
        end
    end

    assign stat_rd     = stat_rd_q;
    assign stat_wr     = stat_wr_q;
    assign stat_replay = stat_replay_q;
`endif

endmodule

// File: tb/tb_dram_req_queue.sv
// Bench for dram_req_queue: a behavioural controller model answers the user
// interface, a negedge monitor scoreboards issued commands and read responses.
module tb_dram_req_queue;
    localparam int AW = 12;
    localparam int DW = 2;
    localparam int DEPTH = 4;

    logic u_clk = 1'b0;
    logic u_rst_n = 1'b0;
    logic req_valid = 1'b0, req_we = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [DW-1:0] req_wdata = '0;
    logic req_ready, rsp_valid, ctl_en, ctl_cmd;
    logic [DW-1:0] rsp_data, ctl_wdata;
    logic [AW-1:0] ctl_addr;
    logic ctl_cmd_ack, ctl_busy, ctl_rdata_vld, mon_ras_n, mon_cas_n, mon_we_n;
    logic [DW-1:0] ctl_rdata;
`ifdef DRAM_REQ_QUEUE_STATS_EN
    logic [15:0] stat_rd, stat_wr, stat_replay;
`endif

    always #5 u_clk = ~u_clk;

    dram_req_queue #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .u_clk(u_clk), .u_rst_n(u_rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .ctl_en(ctl_en), .ctl_addr(ctl_addr), .ctl_cmd(ctl_cmd), .ctl_wdata(ctl_wdata),
        .ctl_cmd_ack(ctl_cmd_ack), .ctl_busy(ctl_busy),
        .ctl_rdata(ctl_rdata), .ctl_rdata_vld(ctl_rdata_vld),
        .mon_ras_n(mon_ras_n), .mon_cas_n(mon_cas_n)
`ifdef DRAM_REQ_QUEUE_STATS_EN
        , .stat_rd(stat_rd), .stat_wr(stat_wr), .stat_replay(stat_replay)
`endif
    );

    int checks = 0, failures = 0;
    int cyc = 0, n_ack = 0, n_cas = 0, n_rsp = 0, cas_cyc = 0;
    int ref_tok = 0, ref_used;
    logic rsp_prev = 1'b0;
    logic [AW+DW:0] exp_cmd[$];
    logic [DW-1:0]  exp_rsp[$];
    logic [AW+DW:0] mon_e;
    logic [DW-1:0]  mon_r;
    logic [DW-1:0]  ref_mem [0:4095];

    // Controller model: ack one cycle after enable, ACT in the ack cycle,
    // CAS next, busy drops the cycle after CAS, read data two cycles after CAS.
    typedef enum {M_IDLE, M_CAS, M_DONE, M_REF} m_e;
    m_e m_st;
    int m_cnt, m_rcnt;
    logic [AW-1:0] m_addr;
    logic m_cmd;
    logic [DW-1:0] m_wd;
    logic [DW-1:0] m_mem [0:4095];

    always @(posedge u_clk or negedge u_rst_n) begin
        if (!u_rst_n) begin
            m_st <= M_IDLE; m_cnt <= 0; m_rcnt <= 0; ref_used <= ref_tok;
            ctl_cmd_ack <= 1'b0; ctl_busy <= 1'b0; ctl_rdata_vld <= 1'b0; ctl_rdata <= '0;
            mon_ras_n <= 1'b1; mon_cas_n <= 1'b1; mon_we_n <= 1'b1;
            m_addr <= '0; m_cmd <= 1'b0; m_wd <= '0;
        end else begin
            ctl_cmd_ack <= 1'b0; ctl_rdata_vld <= 1'b0;
            mon_ras_n <= 1'b1; mon_cas_n <= 1'b1; mon_we_n <= 1'b1;
            if (m_rcnt != 0) begin
                m_rcnt <= m_rcnt - 1;
                if (m_rcnt == 1) begin
                    ctl_rdata_vld <= 1'b1;
                    ctl_rdata <= m_mem[m_addr];
                end
            end
            case (m_st)
                M_IDLE: begin
                    ctl_busy <= 1'b0;
                    if (ctl_en) begin
                        ctl_cmd_ack <= 1'b1; ctl_busy <= 1'b1;
                        m_addr <= ctl_addr; m_cmd <= ctl_cmd; m_wd <= ctl_wdata;
                        if (ref_tok != ref_used) begin
                            ref_used <= ref_used + 1;
                            mon_ras_n <= 1'b0; mon_cas_n <= 1'b0; mon_we_n <= 1'b0;
                            m_cnt <= 2; m_st <= M_REF;
                        end else begin
                            mon_ras_n <= 1'b0; m_st <= M_CAS;
                        end
                    end
                end
                M_CAS: begin
                    mon_cas_n <= 1'b0; mon_we_n <= ~m_cmd;
                    if (m_cmd) m_mem[m_addr] <= m_wd;
                    else m_rcnt <= 2;
                    m_st <= M_DONE;
                end
                M_DONE: begin
                    ctl_busy <= 1'b0; m_st <= M_IDLE;
                end
                M_REF: begin
                    if (m_cnt == 0) begin
                        ctl_busy <= 1'b0; m_st <= M_IDLE;
                    end else m_cnt <= m_cnt - 1;
                end
            endcase
        end
    end

    // Monitor: column commands must match the expected head, responses the
    // expected data, three cycles after the CAS, as single-cycle pulses.
    always @(negedge u_clk) begin
        cyc++;
        if (u_rst_n) begin
            if (ctl_cmd_ack) n_ack++;
            if (mon_ras_n && !mon_cas_n) begin
                n_cas++; cas_cyc = cyc; checks++;
                if (exp_cmd.size() == 0) begin
                    failures++;
                    $display("FAIL cas_unexpected addr=%h", ctl_addr);
                end else begin
                    mon_e = exp_cmd.pop_front();
                    if (!mon_e[AW+DW]) mon_e[DW-1:0] = ctl_wdata;
                    if ({ctl_cmd, ctl_addr, ctl_wdata} !== mon_e || mon_we_n !== ~mon_e[AW+DW]) begin
                        failures++;
                        $display("FAIL cas_cmd got=%h we_n=%b expected=%h", {ctl_cmd, ctl_addr, ctl_wdata}, mon_we_n, mon_e);
                    end
                end
            end
            if (rsp_valid) begin
                n_rsp++; checks++;
                if (exp_rsp.size() == 0) begin
                    failures++;
                    $display("FAIL rsp_unexpected data=%b", rsp_data);
                end else begin
                    mon_r = exp_rsp.pop_front();
                    if (rsp_data !== mon_r) begin
                        failures++;
                        $display("FAIL rsp_data got=%b expected=%b", rsp_data, mon_r);
                    end
                end
                checks++;
                if (cyc - cas_cyc != 3) begin
                    failures++;
                    $display("FAIL rsp_latency got=%0d expected=3", cyc - cas_cyc);
                end
                checks++;
                if (rsp_prev) begin
                    failures++;
                    $display("FAIL rsp_pulse got=2+ cycles expected=1");
                end
            end
            rsp_prev = rsp_valid;
        end else rsp_prev = 1'b0;
    end

    task automatic push(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        int t = 0;
        @(negedge u_clk);
        req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d;
        while (!req_ready && t < 100) begin
            @(negedge u_clk); t++;
        end
        if (!req_ready) begin
            checks++; failures++;
            $display("FAIL push_timeout got=ready0 expected=ready1");
            req_valid = 1'b0;
            return;
        end
        @(posedge u_clk);
        exp_cmd.push_back({we, a, d});
        if (we) ref_mem[a] = d;
        else exp_rsp.push_back(ref_mem[a]);
    endtask

    task automatic idle_in();
        @(negedge u_clk);
        req_valid = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge u_clk);
        u_rst_n = 1'b1;
        @(negedge u_clk);
        checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b expected=1", req_ready); end
        checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid got=%b expected=0", rsp_valid); end
        checks++; if (rsp_data !== '0) begin failures++; $display("FAIL reset_rsp_data got=%b expected=0", rsp_data); end
        checks++; if (ctl_en !== 1'b0) begin failures++; $display("FAIL reset_ctl_en got=%b expected=0", ctl_en); end
    endtask

    task automatic test_write();
        int a0 = n_ack, c0 = n_cas, r0 = n_rsp;
        push(1'b1, 12'h2A3, 2'b10);
        idle_in();
        checks++; if (ctl_en !== 1'b0) begin failures++; $display("FAIL wr_en_push_cycle got=%b expected=0", ctl_en); end
        @(negedge u_clk);
        checks++; if (ctl_en !== 1'b1) begin failures++; $display("FAIL wr_en_next got=%b expected=1", ctl_en); end
        repeat (12) @(negedge u_clk);
        checks++; if (n_ack - a0 != 1) begin failures++; $display("FAIL wr_acks got=%0d expected=1", n_ack - a0); end
        checks++; if (n_cas - c0 != 1) begin failures++; $display("FAIL wr_cas got=%0d expected=1", n_cas - c0); end
        checks++; if (n_rsp - r0 != 0) begin failures++; $display("FAIL wr_rsp got=%0d expected=0", n_rsp - r0); end
        checks++; if (ctl_en !== 1'b0) begin failures++; $display("FAIL wr_en_after got=%b expected=0", ctl_en); end
    endtask

    task automatic test_read();
        int r0 = n_rsp;
        push(1'b0, 12'h2A3, 2'b00);
        idle_in();
        repeat (15) @(negedge u_clk);
        checks++; if (n_rsp - r0 != 1) begin failures++; $display("FAIL rd_rsp_count got=%0d expected=1", n_rsp - r0); end
        checks++; if (rsp_data !== 2'b10) begin failures++; $display("FAIL rd_rsp_hold got=%b expected=10", rsp_data); end
    endtask

    task automatic test_fill();
        int c0 = n_cas, r0 = n_rsp;
        push(1'b1, 12'h011, 2'b01);
        push(1'b0, 12'h011, 2'b00);
        push(1'b1, 12'h122, 2'b11);
        push(1'b0, 12'h122, 2'b00);
        #1;
        checks++; if (req_ready !== 1'b0) begin failures++; $display("FAIL fill_full got=%b expected=0", req_ready); end
        push(1'b0, 12'h011, 2'b00);
        checks++; if (n_cas - c0 != 1) begin failures++; $display("FAIL fill_fifth_after_retire got=%0d expected=1", n_cas - c0); end
        idle_in();
        repeat (50) @(negedge u_clk);
        checks++; if (n_cas - c0 != 5) begin failures++; $display("FAIL fill_cas got=%0d expected=5", n_cas - c0); end
        checks++; if (n_rsp - r0 != 3) begin failures++; $display("FAIL fill_rsp got=%0d expected=3", n_rsp - r0); end
    endtask

    task automatic test_refresh();
        int a0 = n_ack, c0 = n_cas;
        ref_tok++;
        push(1'b1, 12'h3C5, 2'b01);
        idle_in();
        repeat (25) @(negedge u_clk);
        checks++; if (n_ack - a0 != 2) begin failures++; $display("FAIL ref_acks got=%0d expected=2", n_ack - a0); end
        checks++; if (n_cas - c0 != 1) begin failures++; $display("FAIL ref_cas got=%0d expected=1", n_cas - c0); end
`ifdef DRAM_REQ_QUEUE_STATS_EN
        checks++; if (stat_replay !== 16'd1) begin failures++; $display("FAIL ref_stat_replay got=%0d expected=1", stat_replay); end
`endif
    endtask

    task automatic test_back_to_back();
        int t = 0;
        int c0 = n_cas;
        push(1'b1, 12'h055, 2'b00);
        push(1'b1, 12'h066, 2'b01);
        idle_in();
        while (!(mon_ras_n && !mon_cas_n) && t < 30) begin @(negedge u_clk); t++; end
        checks++; if (!(mon_ras_n && !mon_cas_n)) begin failures++; $display("FAIL b2b_cas_timeout got=none expected=cas"); end
        push(1'b1, 12'h077, 2'b10);
        #1;
        checks++; if (ctl_addr !== 12'h066) begin failures++; $display("FAIL b2b_head got=%h expected=066", ctl_addr); end
        checks++; if (n_cas - c0 != 1) begin failures++; $display("FAIL b2b_cas got=%0d expected=1", n_cas - c0); end
        push(1'b1, 12'h088, 2'b11);
        #1;
        checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL b2b_count3 got=%b expected=1", req_ready); end
        push(1'b1, 12'h099, 2'b01);
        #1;
        checks++; if (req_ready !== 1'b0) begin failures++; $display("FAIL b2b_count4 got=%b expected=0", req_ready); end
        idle_in();
        repeat (60) @(negedge u_clk);
        checks++; if (n_cas - c0 != 5) begin failures++; $display("FAIL b2b_total_cas got=%0d expected=5", n_cas - c0); end
    endtask

    task automatic test_reset_mid();
        int t = 0;
        int r0;
        push(1'b0, 12'h2A3, 2'b00);
        push(1'b0, 12'h011, 2'b00);
        push(1'b0, 12'h122, 2'b00);
        idle_in();
        while (!ctl_cmd_ack && t < 30) begin @(negedge u_clk); t++; end
        checks++; if (!ctl_cmd_ack) begin failures++; $display("FAIL rst_ack_timeout got=none expected=ack"); end
        @(negedge u_clk);
        u_rst_n = 1'b0;
        #1;
        exp_cmd.delete();
        exp_rsp.delete();
        r0 = n_rsp;
        checks++; if (ctl_en !== 1'b0) begin failures++; $display("FAIL rst_ctl_en got=%b expected=0", ctl_en); end
        checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL rst_ready got=%b expected=1", req_ready); end
        checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL rst_rsp_valid got=%b expected=0", rsp_valid); end
        checks++; if (rsp_data !== '0) begin failures++; $display("FAIL rst_rsp_data got=%b expected=0", rsp_data); end
        repeat (3) @(negedge u_clk);
        u_rst_n = 1'b1;
        repeat (20) @(negedge u_clk);
        checks++; if (n_rsp != r0) begin failures++; $display("FAIL rst_no_rsp got=%0d expected=%0d", n_rsp, r0); end
        checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL rst_ready_after got=%b expected=1", req_ready); end
        checks++; if (ctl_en !== 1'b0) begin failures++; $display("FAIL rst_en_after got=%b expected=0", ctl_en); end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_fill();
        test_refresh();
        test_back_to_back();
        test_reset_mid();
        checks++; if (exp_cmd.size() != 0) begin failures++; $display("FAIL left_cmds got=%0d expected=0", exp_cmd.size()); end
        checks++; if (exp_rsp.size() != 0) begin failures++; $display("FAIL left_rsps got=%0d expected=0", exp_rsp.size()); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
